servo_io: RTL and testbench
===========================

# servo_io

Parametrised radio-capture / motor-PWM peripheral, the next generation of the fixed 6-in/4-out quad controller. It sits on the processor IO bus beside the UART, I2C and display blocks, and uses the same WE/A/WD/RD slave interface. It measures N_IN servo-style pulse widths in microseconds and drives N_OUT frame-synchronous PWM outputs. Duty updates are glitch-free, and inputs have loss detection and a maskable interrupt.

## Interface
- N_IN, 6: radio capture channels (1..8)
- N_OUT, 4: PWM output channels (1..8)
- DIV, 50: CLK cycles per 1 µs tick (50 MHz clock)
- PERIOD_US, 20000: output frame length in µs
- TIMEOUT_US, 50000: input loss timeout in µs
- FS_US, 1000: failsafe duty in µs
- CNT_W, 16: width of all µs counters/registers
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- WE  in  1  register write strobe
- A  in  5  word register index
- WD  in  32  write data
- RD  out  32  read data, combinational from A
- RADIO  in  N_IN  asynchronous receiver pulses
- ENGINE  out  N_OUT  PWM outputs
- IRQ  out  1  interrupt, level, registered

One clock; reset is asynchronous and active-low.

## Operation
- Register map:
  - A=0..N_IN-1: WIDTH[i] (RO).
  - A=8..8+N_OUT-1: DUTY shadow[j] (RW).
  - A=16: STATUS (RO). [7:0] VALID, [15:8] NEW, [23:16] LOST.
  - A=17: STATUS_CLR. Write 1 to a bit to clear that bit of NEW/LOST.
  - A=18: CTRL (RW). [0] ENABLE, [15:8] NEW IRQ mask, [23:16] LOST IRQ mask.
  - A=19: FRAME, current frame counter (RO).
  - Unmapped indices read 0.
- Prescaler counts 0..DIV-1. A tick is asserted for one cycle at DIV-1.
- Capture, per channel:
  - RADIO goes through a 2-flop synchroniser, then edge detection.
  - A rising edge clears the width counter, which increments on each tick and saturates at 2^CNT_W-1.
  - A falling edge copies the counter to WIDTH[i] and sets VALID[i] and NEW[i].
  - An idle counter also counts ticks since the last rising edge. On reaching TIMEOUT_US it clears VALID[i] and sets LOST[i] once.
- Output:
  - FRAME counts ticks 0..PERIOD_US-1, then wraps.
  - On the tick where FRAME wraps to 0, every active duty loads from its shadow.
  - ENGINE[j] = ENABLE && FRAME < active[j]. ENGINE is registered.
  - Shadow writes of values above PERIOD_US are stored clamped to PERIOD_US (output constantly high).
- IRQ = |((NEW & mask_new) | (LOST & mask_lost)), registered.
- Reset values: all registers, counters, VALID/NEW/LOST, ENGINE, IRQ and the synchronisers are 0. RD reflects the zeroed registers.
- Simultaneous events:
  - Set and W1C of the same flag in one cycle: set wins.
  - Shadow write on the wrap cycle: the new value is loaded that frame.
  - Falling edge and timeout in the same cycle: the edge wins; VALID=1 and LOST is not set.
- Reset mid-pulse or mid-frame: everything returns to reset values immediately. Capture restarts only on the next rising edge.

## Timing
- RADIO edge to WIDTH/flags update: 3 CLK cycles (2 sync + 1 register).
- WIDTH quantisation is ±1 tick. A pulse of W µs reads W or W-1.
- ENGINE transitions occur 1 CLK after the tick edge that crosses the threshold.
- A duty write reaches the pins at the next frame start (worst case PERIOD_US µs).
- IRQ asserts 1 CLK after a flag sets. It deasserts 1 CLK after the clearing W1C or mask write.
- WE is a single-cycle strobe; the register updates at that clock edge. RD has zero wait states.

## Configuration
- SERVO_IO_FAILSAFE_EN defined:
  - While VALID[0] is 0 and CTRL.ENABLE is 1, every active duty loads FS_US at frame start instead of its shadow. Shadows remain readable and writable.
  - Normal loading resumes at the first frame start after VALID[0] returns to 1.
- Not defined: active duties always load from the shadows, regardless of VALID.

## Structure
- Package servo_io_pkg holds the register index constants (WIDTH_BASE=0, DUTY_BASE=8, STATUS=16, STATUS_CLR=17, CTRL=18, FRAME=19), the STATUS/CTRL bit field offsets and a ctrl_t packed struct.
- Sub-module servo_capture holds one input channel: synchroniser, edge detection, width counter, timeout counter and VALID/NEW/LOST. It is instantiated N_IN times in a generate loop.
- The prescaler, frame counter, PWM compare, register file and IRQ logic stay in servo_io.

## Test plan
- Reset: RESET_N low mid-frame, then released. ENGINE=0, IRQ=0, every register reads 0, FRAME restarts at 0.
- Capture: 1500 µs pulse on RADIO[2]. WIDTH[2] reads 1499 or 1500; STATUS bits 2 and 10 set. W1C 0x400 clears NEW[2] and leaves VALID[2] set.
- PWM glitch-free update: ENABLE=1, DUTY[1]=1000, then DUTY[1]=1800 written mid-frame. The current frame's high time stays 1000 µs; the next frame is 1800 µs. A write of 25000 gives a constant high.
- Loss/IRQ: CTRL.LOST mask bit 0 set, RADIO[0] idle for 50 ms after one pulse. VALID[0]=0, LOST[0]=1, IRQ=1. W1C drops IRQ 1 cycle later.
- Collision: a falling edge on ch3 and a W1C of NEW[3] land in the same cycle. NEW[3] remains 1.
- Failsafe (macro on): RADIO[0] lost with DUTY[0..3]=1700. From the next frame all ENGINE high times are 1000 µs. A new pulse on RADIO[0] restores 1700 µs at the following frame.

Source files
------------

// File: rtl/servo_io_pkg.sv
// servo_io_pkg: register indices, STATUS/CTRL field offsets and the CTRL layout
// shared by servo_io and servo_capture.
package servo_io_pkg;

    // Word register indices on the A bus
    localparam logic [4:0] WIDTH_BASE = 5'd0;
    localparam logic [4:0] DUTY_BASE  = 5'd8;
    localparam logic [4:0] STATUS     = 5'd16;
    localparam logic [4:0] STATUS_CLR = 5'd17;
    localparam logic [4:0] CTRL       = 5'd18;
    localparam logic [4:0] FRAME      = 5'd19;

    // STATUS / STATUS_CLR field offsets (8 bits each)
    localparam int unsigned ST_VALID_LSB = 0;
    localparam int unsigned ST_NEW_LSB   = 8;
    localparam int unsigned ST_LOST_LSB  = 16;

    // CTRL field offsets
    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_NEW_MASK_LSB  = 8;
    localparam int unsigned CTRL_LOST_MASK_LSB = 16;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] lost_mask;
        logic [7:0] new_mask;
        logic [6:0] rsvd_lo;
        logic       enable;
    } ctrl_t;

endpackage

// File: rtl/servo_capture.sv
// servo_capture: one radio input channel. Synchronises the pulse, measures its
// high time in ticks, and tracks VALID/NEW/LOST with loss timeout.
module servo_capture import servo_io_pkg::*; #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT_US = 50000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             radio_i,
    input  logic             clr_new_i,
    input  logic             clr_lost_i,
    output logic [CNT_W-1:0] width_o,
    output logic             valid_o,
    output logic             new_o,
    output logic             lost_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT_US - 1);

    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, idle_q, idle_d, width_q, width_d;
    logic             valid_q, valid_d, new_q, new_d, lost_q, lost_d;
    logic             rise, fall, timeout;

    // Edge detection, counters and flag next-state; a falling edge beats a timeout,
    // and a flag set beats its W1C
    always_comb begin
        sync1_d = radio_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        fall    = ~sync2_q & prev_q;
        // Idle timer only runs once a first rising edge has been seen
        timeout = tick_i && armed_q && (idle_q == TO_M1) && !rise && !fall;

        armed_d = armed_q | rise;

        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (tick_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        idle_d = idle_q;
        if (rise) begin
            idle_d = '0;
        end else if (tick_i && armed_q && idle_q != TO_C) begin
            idle_d = idle_q + 1'b1;
        end

        width_d = fall ? cnt_q : width_q;

        valid_d = valid_q;
        if (fall) begin
            valid_d = 1'b1;
        end else if (timeout) begin
            valid_d = 1'b0;
        end

        new_d = new_q;
        if (fall) begin
            new_d = 1'b1;
        end else if (clr_new_i) begin
            new_d = 1'b0;
        end

        lost_d = lost_q;
        if (timeout) begin
            lost_d = 1'b1;
        end else if (clr_lost_i) begin
            lost_d = 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            idle_q  <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            width_q <= width_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            lost_q  <= lost_d;
        end
    end

    assign width_o = width_q;
    assign valid_o = valid_q;
    assign new_o   = new_q;
    assign lost_o  = lost_q;

endmodule

// File: rtl/servo_io.sv
// servo_io: N_IN radio pulse-width capture channels and N_OUT frame-synchronous
// PWM outputs on the WE/A/WD/RD register bus.
// Optional build macro SERVO_IO_FAILSAFE_EN: while VALID[0] is low and ENABLE is
// set, active duties load FS_US at frame start instead of the shadows.
module servo_io import servo_io_pkg::*; #(
    parameter int unsigned N_IN       = 6,
    parameter int unsigned N_OUT      = 4,
    parameter int unsigned DIV        = 50,
    parameter int unsigned PERIOD_US  = 20000,
    parameter int unsigned TIMEOUT_US = 50000,
    parameter int unsigned FS_US      = 1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             WE,
    input  logic [4:0]       A,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    input  logic [N_IN-1:0]  RADIO,
    output logic [N_OUT-1:0] ENGINE,
    output logic             IRQ
);

    localparam int unsigned      PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(PERIOD_US - 1);
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD_US);
    localparam logic [CNT_W-1:0] FS_C      = CNT_W'(FS_US);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             tick, wrap, fs_active;
    logic [CNT_W-1:0] shadow_q [N_OUT];
    logic [CNT_W-1:0] shadow_d [N_OUT];
    logic [CNT_W-1:0] active_q [N_OUT];
    logic [CNT_W-1:0] active_d [N_OUT];
    logic [N_OUT-1:0] engine_q, engine_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] width [N_IN];
    logic [N_IN-1:0]  valid, new_flag, lost, clr_new, clr_lost;
    logic [7:0]       valid_v, new_v, lost_v;

    for (genvar g = 0; g < N_IN; g++) begin : g_cap
        servo_capture #(
            .CNT_W      (CNT_W),
            .TIMEOUT_US (TIMEOUT_US)
        ) u_cap (
            .clk_i      (CLK),
            .rst_ni     (RESET_N),
            .tick_i     (tick),
            .radio_i    (RADIO[g]),
            .clr_new_i  (clr_new[g]),
            .clr_lost_i (clr_lost[g]),
            .width_o    (width[g]),
            .valid_o    (valid[g]),
            .new_o      (new_flag[g]),
            .lost_o     (lost[g])
        );
    end

`ifdef SERVO_IO_FAILSAFE_EN
    assign fs_active = ctrl_q.enable && !valid[0];
`else
    assign fs_active = 1'b0;
`endif

    // Prescaler, frame counter, register writes, duty reload, PWM compare and IRQ
    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        wrap    = tick && (frame_q == FRAME_MAX);
        frame_d = frame_q;
        if (tick) begin
            frame_d = wrap ? '0 : frame_q + 1'b1;
        end

        ctrl_d = ctrl_q;
        if (WE && A == CTRL) begin
            ctrl_d           = '0;
            ctrl_d.enable    = WD[CTRL_ENABLE_BIT];
            ctrl_d.new_mask  = WD[CTRL_NEW_MASK_LSB +: 8];
            ctrl_d.lost_mask = WD[CTRL_LOST_MASK_LSB +: 8];
        end

        for (int j = 0; j < N_OUT; j++) begin
            shadow_d[j] = shadow_q[j];
            if (WE && A == DUTY_BASE + 5'(j)) begin
                shadow_d[j] = (WD > 32'(PERIOD_US)) ? PERIOD_C : WD[CNT_W-1:0];
            end
            // Load from shadow_d so a write on the wrap cycle lands this frame
            active_d[j] = active_q[j];
            if (wrap) begin
                active_d[j] = fs_active ? FS_C : shadow_d[j];
            end
            engine_d[j] = ctrl_q.enable && (frame_q < active_q[j]);
        end

        for (int i = 0; i < N_IN; i++) begin
            clr_new[i]  = WE && (A == STATUS_CLR) && WD[ST_NEW_LSB + i];
            clr_lost[i] = WE && (A == STATUS_CLR) && WD[ST_LOST_LSB + i];
        end

        valid_v = '0;
        new_v   = '0;
        lost_v  = '0;
        valid_v[N_IN-1:0] = valid;
        new_v[N_IN-1:0]   = new_flag;
        lost_v[N_IN-1:0]  = lost;
        irq_d = |((new_v & ctrl_q.new_mask) | (lost_v & ctrl_q.lost_mask));
    end

    // Combinational read mux; unmapped indices read 0
    always_comb begin
        RD = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (A == WIDTH_BASE + 5'(i)) begin
                RD = 32'(width[i]);
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (A == DUTY_BASE + 5'(j)) begin
                RD = 32'(shadow_q[j]);
            end
        end
        case (A)
            STATUS: begin
                RD[ST_VALID_LSB +: 8] = valid_v;
                RD[ST_NEW_LSB +: 8]   = new_v;
                RD[ST_LOST_LSB +: 8]  = lost_v;
            end
            CTRL:    RD = ctrl_q;
            FRAME:   RD = 32'(frame_q);
            default: ;
        endcase
    end

    // Peripheral state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q    <= '0;
            frame_q  <= '0;
            ctrl_q   <= '0;
            engine_q <= '0;
            irq_q    <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                shadow_q[j] <= '0;
                active_q[j] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            frame_q  <= frame_d;
            ctrl_q   <= ctrl_d;
            engine_q <= engine_d;
            irq_q    <= irq_d;
            for (int j = 0; j < N_OUT; j++) begin
                shadow_q[j] <= shadow_d[j];
                active_q[j] <= active_d[j];
            end
        end
    end

    assign ENGINE = engine_q;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_servo_io.sv
// tb_servo_io: directed bench for servo_io with a scaled-down timebase
// (DIV=2, 100 us frame, 2000 us loss timeout, 40 us failsafe duty).
`timescale 1ns/1ps
module tb_servo_io;

    localparam int unsigned N_IN  = 6;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned DIV   = 2;

    logic             CLK;
    logic             RESET_N;
    logic             WE;
    logic [4:0]       A;
    logic [31:0]      WD;
    logic [31:0]      RD;
    logic [N_IN-1:0]  RADIO;
    logic [N_OUT-1:0] ENGINE;
    logic             IRQ;

    int n_vec = 0;
    int n_err = 0;

    servo_io #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .DIV        (DIV),
        .PERIOD_US  (100),
        .TIMEOUT_US (2000),
        .FS_US      (40),
        .CNT_W      (16)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .WE      (WE),
        .A       (A),
        .WD      (WD),
        .RD      (RD),
        .RADIO   (RADIO),
        .ENGINE  (ENGINE),
        .IRQ     (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge CLK);
        WE = 1'b1;
        A  = a;
        WD = d;
        @(negedge CLK);
        WE = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = RD;
    endtask

    // High for us microseconds; returns at the negedge where RADIO drops
    task automatic pulse(input int ch, input int us);
        @(negedge CLK);
        RADIO[ch] = 1'b1;
        repeat (us * DIV) @(negedge CLK);
        RADIO[ch] = 1'b0;
    endtask

    // Length in cycles of the next complete ENGINE[ch] high pulse (-1 on timeout);
    // optionally writes DUTY[ch]=wr_val wr_at cycles into that pulse
    task automatic measure_high(input int ch, input int wr_at, input logic [31:0] wr_val,
                                output int cyc);
        int n;
        cyc = 0;
        n   = 0;
        @(posedge CLK); #1;
        while (ENGINE[ch] !== 1'b0 && n < 2000) begin
            @(posedge CLK); #1; n++;
        end
        n = 0;
        while (ENGINE[ch] !== 1'b1 && n < 2000) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= 2000) begin
            cyc = -1;
        end else begin
            while (ENGINE[ch] === 1'b1 && cyc < 2000) begin
                if (cyc == wr_at) begin
                    WE = 1'b1;
                    A  = 5'(8 + ch);
                    WD = wr_val;
                end
                @(posedge CLK); #1;
                WE = 1'b0;
                cyc++;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int          c;
        int          lows;
        int          n;

        RESET_N = 1'b0;
        WE      = 1'b0;
        A       = '0;
        WD      = '0;
        RADIO   = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;

        // Reset mid-frame while ENGINE[0] is high
        bus_write(5'd18, 32'h1);
        bus_write(5'd8, 32'd50);
        repeat (240) @(negedge CLK);
        #1;
        check("pre_reset_engine0", 32'(ENGINE[0]), 32'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        check("reset_engine", 32'(ENGINE), 32'd0);
        check("reset_irq", 32'(IRQ), 32'd0);
        for (int a = 0; a < 32; a++) begin
            A = 5'(a);
            #1;
            check($sformatf("reset_rd%0d", a), RD, 32'd0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        bus_read(5'd19, d);
        check("frame_restart", d, 32'd0);
        repeat (20) @(negedge CLK);
        bus_read(5'd19, d);
        check("frame_after_20clk", d, 32'd10);
        check("engine_disabled", 32'(ENGINE), 32'd0);

        // Capture: 15 us on ch2, flags appear on the third clock after the edge
        pulse(2, 15);
        @(negedge CLK);
        @(negedge CLK);
        bus_read(5'd16, d);
        check("status_before_sync", d, 32'h0);
        @(negedge CLK);
        bus_read(5'd16, d);
        check("status_after_fall", d, 32'h404);
        bus_read(5'd2, d);
        check("width2_in_range", 32'(d == 32'd15 || d == 32'd14), 32'd1);
        bus_write(5'd17, 32'h400);
        bus_read(5'd16, d);
        check("status_w1c_new2", d, 32'h004);
        bus_read(5'd6, d);
        check("unmapped_a6", d, 32'd0);

        // Collision: falling edge on ch3 and W1C of NEW[3] on the same clock
        pulse(3, 10);
        repeat (4) @(negedge CLK);
        bus_read(5'd16, d);
        check("new3_first", 32'(d[11]), 32'd1);
        pulse(3, 10);
        @(negedge CLK);
        @(negedge CLK);
        WE = 1'b1;
        A  = 5'd17;
        WD = 32'h800;
        @(negedge CLK);
        WE = 1'b0;
        bus_read(5'd16, d);
        check("collision_new3", 32'(d[11]), 32'd1);
        bus_write(5'd17, 32'h800);
        bus_read(5'd16, d);
        check("w1c_new3", 32'(d[11]), 32'd0);

        // PWM on ch1; a pulse on ch0 keeps VALID[0] up for the failsafe build
        pulse(0, 20);
        bus_write(5'd18, 32'h1);
        bus_write(5'd9, 32'd30);
        bus_read(5'd18, d);
        check("ctrl_readback", d, 32'h1);
        measure_high(1, -1, 32'd0, c);
        check("pwm_duty30", 32'(c), 32'd60);
        measure_high(1, 10, 32'd70, c);
        check("pwm_midframe_write", 32'(c), 32'd60);
        measure_high(1, -1, 32'd0, c);
        check("pwm_duty70", 32'(c), 32'd140);
        bus_write(5'd9, 32'd250);
        bus_read(5'd9, d);
        check("duty_clamped", d, 32'd100);
        repeat (400) @(negedge CLK);
        lows = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge CLK); #1;
            if (ENGINE[1] !== 1'b1) lows++;
        end
        check("pwm_const_high", 32'(lows), 32'd0);
        check("engine0_duty0", 32'(ENGINE[0]), 32'd0);
        bus_read(5'd12, d);
        check("unmapped_a12", d, 32'd0);
        bus_read(5'd20, d);
        check("unmapped_a20", d, 32'd0);

        // Loss on ch0 with LOST[0] unmasked
        bus_write(5'd18, 32'h0001_0001);
        bus_read(5'd18, d);
        check("ctrl_lost_mask", d, 32'h0001_0001);
        n = 0;
        while (IRQ !== 1'b1 && n < 6000) begin
            @(negedge CLK); n++;
        end
        check("irq_on_loss", 32'(IRQ), 32'd1);
        bus_read(5'd16, d);
        check("valid0_cleared", 32'(d[0]), 32'd0);
        check("lost0_set", 32'(d[16]), 32'd1);
        bus_write(5'd17, 32'h1_0000);
        #1;
        check("irq_same_clk_w1c", 32'(IRQ), 32'd1);
        @(negedge CLK);
        #1;
        check("irq_dropped", 32'(IRQ), 32'd0);
        bus_read(5'd16, d);
        check("lost0_cleared", 32'(d[16]), 32'd0);

        // Duties 70 us while ch0 is lost, then ch0 recovers
        for (int j = 0; j < 4; j++) bus_write(5'(8 + j), 32'd70);
        measure_high(0, -1, 32'd0, c);
`ifdef SERVO_IO_FAILSAFE_EN
        check("fs_engine0", 32'(c), 32'd80);
`else
        check("nofs_engine0", 32'(c), 32'd140);
`endif
        measure_high(3, -1, 32'd0, c);
`ifdef SERVO_IO_FAILSAFE_EN
        check("fs_engine3", 32'(c), 32'd80);
`else
        check("nofs_engine3", 32'(c), 32'd140);
`endif
        pulse(0, 20);
        repeat (5) @(negedge CLK);
        measure_high(0, -1, 32'd0, c);
        check("recovered_engine0", 32'(c), 32'd140);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
